// File: rtl/mem_bus_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto a single SRAM-like bus bridge,
// one transaction outstanding at a time, with a sticky watchdog flag.
module mem_bus_arbiter #(
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_WAIT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_done,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [1:0] state;
  logic       owner_data;
  logic       last_data;
  logic [7:0] wait_cnt;
  logic       grant_data;
  logic       complete;
  logic [1:0] st_size;
  logic [1:0] st_off;

  assign inst_stall = inst_req & ~inst_done;
  assign data_stall = data_req & ~data_done;

  always_comb begin
    grant_data = 1'b0;
    if (data_req && !inst_req)
      grant_data = 1'b1;
    else if (data_req && inst_req)
      grant_data = (DATA_PRIORITY != 0) || !last_data;
  end

  // Store byte select -> transfer size and byte offset within the word
  always_comb begin
    st_size = 2'd2;
    st_off  = 2'd0;
    case (data_wstrb)
      4'b0001: begin st_size = 2'd0; st_off = 2'd0; end
      4'b0010: begin st_size = 2'd0; st_off = 2'd1; end
      4'b0100: begin st_size = 2'd0; st_off = 2'd2; end
      4'b1000: begin st_size = 2'd0; st_off = 2'd3; end
      4'b0011: begin st_size = 2'd1; st_off = 2'd0; end
      4'b1100: begin st_size = 2'd1; st_off = 2'd2; end
      default: begin st_size = 2'd2; st_off = 2'd0; end
    endcase
  end

  assign complete = ((state == ADDR) && bus_addr_ok && bus_data_ok) ||
                    ((state == DATA) && bus_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_data  <= 1'b0;
      last_data   <= 1'b0;
      wait_cnt    <= '0;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_size    <= '0;
      bus_addr    <= '0;
      bus_wstrb   <= '0;
      bus_wdata   <= '0;
      inst_done   <= 1'b0;
      data_done   <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
      bus_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (inst_req || data_req) begin
            state      <= ADDR;
            bus_req    <= 1'b1;
            owner_data <= grant_data;
            last_data  <= grant_data;
            if (grant_data) begin
              bus_wr    <= data_wr;
              bus_wdata <= data_wdata;
              if (data_wr) begin
                bus_size  <= st_size;
                bus_addr  <= {data_addr[31:2], st_off};
                bus_wstrb <= data_wstrb;
              end else begin
                bus_size  <= 2'd2;
                bus_addr  <= data_addr;
                bus_wstrb <= '0;
              end
            end else begin
              bus_wr    <= 1'b0;
              bus_wdata <= '0;
              bus_size  <= 2'd2;
              bus_addr  <= inst_addr;
              bus_wstrb <= '0;
            end
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (!bus_data_ok)
              state <= DATA;
          end
        end
        DATA: ;
        DONE: begin
          inst_done <= 1'b0;
          data_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Done is raised on entry to DONE so it is high for exactly that cycle
      if (complete) begin
        state <= DONE;
        if (owner_data) begin
          data_done <= 1'b1;
          if (!bus_wr)
            data_rdata <= bus_rdata;
        end else begin
          inst_done  <= 1'b1;
          inst_rdata <= bus_rdata;
        end
      end

      if ((state == ADDR) || (state == DATA)) begin
        if (wait_cnt != '1)
          wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == WAIT_LIMIT)
          bus_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam bit PRIO = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        inst_done, inst_stall, data_done, data_stall;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_timeout;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  logic        inst_done_rr, inst_stall_rr, data_done_rr, data_stall_rr;
  logic [31:0] inst_rdata_rr, data_rdata_rr;
  logic        bus_req_rr, bus_wr_rr, bus_timeout_rr;
  logic [1:0]  bus_size_rr;
  logic [31:0] bus_addr_rr, bus_wdata_rr;
  logic [3:0]  bus_wstrb_rr;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic        m_last_data = 1'b0;
  logic [31:0] m_irdata = '0;
  logic [31:0] m_drdata = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_PRIORITY(1), .MAX_WAIT(255)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done),
    .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_done(data_done),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
  );

  // Round-robin instance shares all inputs; handshake timing is owner-independent
  mem_bus_arbiter #(.DATA_PRIORITY(0), .MAX_WAIT(255)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done_rr),
    .inst_rdata(inst_rdata_rr), .inst_stall(inst_stall_rr),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_done(data_done_rr),
    .data_rdata(data_rdata_rr), .data_stall(data_stall_rr),
    .bus_req(bus_req_rr), .bus_wr(bus_wr_rr), .bus_size(bus_size_rr), .bus_addr(bus_addr_rr),
    .bus_wstrb(bus_wstrb_rr), .bus_wdata(bus_wdata_rr), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout_rr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last_data = 1'b0;
    m_irdata = '0;
    m_drdata = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_wr"}, bus_wr, 0);
    chk({tag, "_bus_size"}, bus_size, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_inst_done"}, inst_done, 0);
    chk({tag, "_data_done"}, data_done, 0);
    chk({tag, "_inst_rdata"}, inst_rdata, 0);
    chk({tag, "_data_rdata"}, data_rdata, 0);
    chk({tag, "_timeout"}, bus_timeout, 0);
    chk({tag, "_stalls"}, {inst_stall, data_stall}, 0);
  endtask

  // Full transaction from an IDLE negedge: model grant, serve the bus, check done.
  task automatic run_txn(input int ad, input int dd, input bit same, input bit hold,
                         input logic [31:0] rd);
    logic        wd, ewr;
    logic [1:0]  esz;
    logic [31:0] ea, ewd;
    logic [3:0]  es;
    int unsigned n;
    if (data_req && inst_req) wd = PRIO ? 1'b1 : !m_last_data;
    else wd = data_req;
    ewd = '0;
    if (!wd) begin
      ewr = 1'b0; esz = 2'd2; ea = inst_addr; es = 4'd0;
    end else if (!data_wr) begin
      ewr = 1'b0; esz = 2'd2; ea = data_addr; es = 4'd0;
    end else begin
      ewr = 1'b1; es = data_wstrb; ewd = data_wdata;
      n = $countones(data_wstrb);
      ea = data_addr;
      esz = 2'd2;
      if (n == 1) begin
        esz = 2'd0;
        for (int unsigned b = 0; b < 4; b++)
          if (data_wstrb[b]) ea = data_addr + b;
      end else if (data_wstrb == 4'b0011) begin
        esz = 2'd1;
      end else if (data_wstrb == 4'b1100) begin
        esz = 2'd1; ea = data_addr + 2;
      end
    end
    m_last_data = wd;

    @(negedge clk);
    chk("grant_bus_req", bus_req, 1);
    chk("grant_stall", wd ? data_stall : inst_stall, 1);
    if (!hold) begin
      if (wd) begin
        data_addr = $urandom & ~32'h3; data_wstrb = 4'($urandom); data_wdata = $urandom;
      end else begin
        inst_addr = $urandom & ~32'h3;
      end
    end
    for (int i = 0; i < ad; i++) begin
      @(negedge clk);
      if (i == 247) chk("timeout_early", bus_timeout, 0);
    end
    chk("addr_bus_req", bus_req, 1);
    chk("bus_addr", bus_addr, ea);
    chk("bus_size", bus_size, esz);
    chk("bus_wstrb", bus_wstrb, es);
    chk("bus_wr", bus_wr, ewr);
    if (ewr) chk("bus_wdata", bus_wdata, ewd);
    bus_addr_ok = 1'b1;
    bus_data_ok = same;
    bus_rdata = same ? rd : $urandom;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (!same) begin
      chk("data_bus_req", bus_req, 0);
      for (int i = 0; i < dd; i++) @(negedge clk);
      bus_data_ok = 1'b1;
      bus_rdata = rd;
      @(negedge clk);
      bus_data_ok = 1'b0;
    end
    if (!wd) m_irdata = rd;
    else if (!ewr) m_drdata = rd;
    chk("inst_done", inst_done, !wd);
    chk("data_done", data_done, wd);
    chk("inst_rdata", inst_rdata, m_irdata);
    chk("data_rdata", data_rdata, m_drdata);
    chk("done_bus_req", bus_req, 0);
    chk("done_stall", wd ? data_stall : inst_stall, 0);
    if (!hold) begin
      if (wd) data_req = 1'b0;
      else inst_req = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse_end", {inst_done, data_done}, 0);
    chk("rdata_hold", {inst_rdata ^ m_irdata, data_rdata ^ m_drdata}, 0);
  endtask

  initial begin
    logic [3:0] strb_tab [0:6];
    strb_tab[0] = 4'b0001; strb_tab[1] = 4'b0010; strb_tab[2] = 4'b0100;
    strb_tab[3] = 4'b1000; strb_tab[4] = 4'b0011; strb_tab[5] = 4'b1100;
    strb_tab[6] = 4'b1111;

    do_reset();
    check_zero("reset");

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    run_txn(2, 3, 1'b0, 1'b0, 32'h3C1D_0000);
    repeat (3) @(negedge clk);
    chk("fetch_rdata_held", inst_rdata, 32'h3C1D_0000);
    chk("fetch_size", bus_size, 2);

    // SB / SH mapping
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0100;
    data_addr = 32'h8000_1000; data_wdata = 32'h5A5A_5A5A;
    run_txn(1, 1, 1'b0, 1'b0, 32'h0);
    chk("sb_addr", bus_addr, 32'h8000_1002);
    chk("sb_size", bus_size, 0);
    chk("sb_wstrb", bus_wstrb, 4'b0100);
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b1100;
    data_addr = 32'h8000_1000; data_wdata = 32'hBEEF_BEEF;
    run_txn(0, 2, 1'b0, 1'b0, 32'h0);
    chk("sh_addr", bus_addr, 32'h8000_1002);
    chk("sh_size", bus_size, 1);

    // Simultaneous requests with data priority
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000;
    run_txn(1, 0, 1'b0, 1'b0, 32'h1111_2222);
    chk("prio_data_first", data_rdata, 32'h1111_2222);
    run_txn(0, 1, 1'b0, 1'b0, 32'h3333_4444);
    chk("prio_inst_second", inst_rdata, 32'h3333_4444);

    // Same-cycle handshake
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000;
    run_txn(0, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
    chk("same_no_extra_req", bus_req, 0);

    // Reset while in DATA, late data_ok ignored
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_4000;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    data_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last_data = 1'b0; m_irdata = '0; m_drdata = '0;
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_data_ok = 1'b0;
    check_zero("midreset");
    @(negedge clk);
    chk("midreset_no_done", {inst_done, data_done, bus_req}, 0);

    // Round-robin alternation on the DATA_PRIORITY=0 instance
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_0A00;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0D00;
    for (int unsigned t = 0; t < 4; t++) begin
      run_txn(0, 0, 1'b0, 1'b1, $urandom);
      chk("rr_grant", bus_addr_rr, (t % 2 == 0) ? 32'h0000_0D00 : 32'h0000_0A00);
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Randomized traffic
    for (int unsigned t = 0; t < 40; t++) begin
      if (!inst_req && ($urandom_range(1, 0) == 1)) begin
        inst_req = 1'b1; inst_addr = $urandom & ~32'h3;
      end
      if (!data_req && ($urandom_range(1, 0) == 1)) begin
        data_req = 1'b1; data_wr = 1'($urandom);
        data_wstrb = ($urandom_range(7, 0) == 7) ? 4'($urandom) : strb_tab[$urandom_range(6, 0)];
        data_addr = $urandom & ~32'h3; data_wdata = $urandom;
      end
      if (!inst_req && !data_req) begin
        inst_req = 1'b1; inst_addr = $urandom & ~32'h3;
      end
      run_txn($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0) == 0,
              1'b0, $urandom);
      chk("rand_timeout", bus_timeout, 0);
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Watchdog: addr_ok withheld for 300 cycles
    inst_req = 1'b1; inst_addr = 32'h0000_5000;
    run_txn(300, 1, 1'b0, 1'b0, 32'h7777_7777);
    chk("timeout_set", bus_timeout, 1);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", bus_timeout, 1);
    do_reset();
    chk("timeout_cleared", bus_timeout, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
